// File: rtl/mul_wb_seq.sv
// Multiply write-back sequencer: drives an external multiplier over the shared bus
// and writes 32/64-bit results (optionally accumulated, macro MUL_WB_ACC_EN) to the register file.
module mul_wb_seq (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        long_op,
    input  logic        sgn,
    input  logic        acc,
    input  logic [3:0]  rd_lo,
    input  logic [3:0]  rd_hi,
    input  logic [31:0] acc_lo,
    input  logic [31:0] acc_hi,
    input  logic [31:0] bus,
    output logic        LD_MUL,
    output logic        Gate_MUL,
    output logic        MUL_HiLo,
    output logic        U,
    output logic        busy,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        done,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RD_LO = 3'd2,
        RD_HI = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic        long_q;
    logic        sgn_q;
    logic        acc_q;
    logic [3:0]  rd_lo_q;
    logic [3:0]  rd_hi_q;
    logic [31:0] acc_lo_q;
    logic [31:0] acc_hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        accept;

    // Handshake: a request is taken when start=1 while busy=0 (IDLE); start is
    // ignored whenever busy=1, and done pulses with the last register write.
    assign accept = (state == IDLE) && start;

`ifdef MUL_WB_ACC_EN
    logic acc_in;
    assign acc_in = acc;
`else
    logic acc_in;
    logic unused_acc;
    assign acc_in     = 1'b0;
    assign unused_acc = ^{acc, acc_lo, acc_hi};
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            long_q   <= 1'b0;
            sgn_q    <= 1'b0;
            acc_q    <= 1'b0;
            rd_lo_q  <= 4'd0;
            rd_hi_q  <= 4'd0;
            acc_lo_q <= 32'd0;
            acc_hi_q <= 32'd0;
            lo_q     <= 32'd0;
            hi_q     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                long_q  <= long_op;
                sgn_q   <= sgn;
                acc_q   <= acc_in;
                rd_lo_q <= rd_lo;
                rd_hi_q <= rd_hi;
`ifdef MUL_WB_ACC_EN
                acc_lo_q <= acc_lo;
                acc_hi_q <= acc_hi;
`endif
            end
            if (state == RD_LO) lo_q <= bus;
            if (state == RD_HI) hi_q <= bus;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = RD_LO;
            RD_LO:   state_nxt = long_q ? RD_HI : WR_LO;
            RD_HI:   state_nxt = WR_LO;
            WR_LO:   state_nxt = long_q ? WR_HI : IDLE;
            WR_HI:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Low add is shared by both write states so its carry is available in WR_HI.
    logic [32:0] lo_sum;
    logic [31:0] hi_sum;

`ifdef MUL_WB_ACC_EN
    always_comb begin
        lo_sum = {1'b0, lo_q};
        hi_sum = hi_q;
        if (acc_q) begin
            lo_sum = {1'b0, lo_q} + {1'b0, acc_lo_q};
            hi_sum = hi_q + acc_hi_q + {31'd0, lo_sum[32]};
        end
    end
`else
    logic unused_fields;
    assign unused_fields = ^{acc_q, acc_lo_q, acc_hi_q};
    assign lo_sum = {1'b0, lo_q};
    assign hi_sum = hi_q;
`endif

    always_comb begin
        LD_MUL   = 1'b0;
        Gate_MUL = 1'b0;
        MUL_HiLo = 1'b0;
        busy     = (state != IDLE);
        rf_we    = 1'b0;
        rf_waddr = 4'd0;
        rf_wdata = 32'd0;
        done     = 1'b0;
        case (state)
            LOAD: LD_MUL = 1'b1;
            RD_LO: begin
                LD_MUL   = 1'b1;
                Gate_MUL = 1'b1;
            end
            RD_HI: begin
                LD_MUL   = 1'b1;
                Gate_MUL = 1'b1;
                MUL_HiLo = 1'b1;
            end
            WR_LO: begin
                rf_we    = 1'b1;
                rf_waddr = rd_lo_q;
                rf_wdata = lo_sum[31:0];
                done     = !long_q;
            end
            WR_HI: begin
                rf_we    = 1'b1;
                rf_waddr = rd_hi_q;
                rf_wdata = hi_sum;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign U         = sgn_q;
    assign state_dbg = state;

endmodule

// File: doc/mul_wb_seq.md
MUL_WB_SEQ -- requirements
Module: mul_wb_seq

Interface
REQ-001 SHALL have port CLK, input, 1: system clock; all state changes on its rising edge.
REQ-002 SHALL have port RST_N, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: request to begin one multiply instruction; sampled only in IDLE.
REQ-004 SHALL have port long_op, input, 1: 1 = 64-bit result (xMULL/xMLAL), 0 = 32-bit result (MUL/MLA).
REQ-005 SHALL have port sgn, input, 1: 1 = signed operands; sampled at accept.
REQ-006 SHALL have port acc, input, 1: 1 = accumulate variant; sampled at accept.
REQ-007 SHALL have port rd_lo, input, 4: destination of the low word (Rd for 32-bit ops); sampled at accept.
REQ-008 SHALL have port rd_hi, input, 4: destination of the high word; sampled at accept.
REQ-009 SHALL have port acc_lo, input, 32: low accumulate addend; sampled at accept.
REQ-010 SHALL have port acc_hi, input, 32: high accumulate addend; sampled at accept.
REQ-011 SHALL have port bus, input, 32: shared datapath bus carrying the multiplier output while Gate_MUL=1.
REQ-012 SHALL have ports LD_MUL, Gate_MUL, MUL_HiLo and U, each output, 1: multiplier controls; U = latched sgn.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port rf_we, output, 1: register-file write strobe.
REQ-015 SHALL have port rf_waddr, output, 4: register-file write address.
REQ-016 SHALL have port rf_wdata, output, 32: register-file write data.
REQ-017 SHALL have port done, output, 1: one-cycle pulse coincident with the final write.

Function
REQ-018 SHALL implement the states IDLE, LOAD, RD_LO, RD_HI, WR_LO and WR_HI.
REQ-019 SHALL move IDLE->LOAD on start=1 (cycle T) and latch long_op, sgn, acc, rd_lo, rd_hi, acc_lo and acc_hi.
REQ-020 SHALL assert LD_MUL=1 in LOAD, RD_LO and RD_HI, and 0 elsewhere.
REQ-021 SHALL drive Gate_MUL=1 with MUL_HiLo=0 in RD_LO and capture bus into lo_q.
REQ-022 SHALL drive Gate_MUL=1 with MUL_HiLo=1 in RD_HI and capture bus into hi_q.
REQ-023 SHALL drive Gate_MUL=0 in all other states.
REQ-024 SHALL follow, for 32-bit ops: LOAD(T+1) -> RD_LO(T+2) -> WR_LO(T+3, done=1) -> IDLE.
REQ-025 SHALL follow, for 64-bit ops: LOAD(T+1) -> RD_LO(T+2) -> RD_HI(T+3) -> WR_LO(T+4) -> WR_HI(T+5, done=1) -> IDLE.
REQ-026 SHALL, in WR_LO, assert rf_we=1 with rf_waddr=rd_lo and rf_wdata=lo_q+acc_lo when acc=1, else lo_q.
REQ-027 SHALL, in WR_HI, assert rf_we=1 with rf_waddr=rd_hi and rf_wdata=hi_q+acc_hi+carry-out of the low add when acc=1, else hi_q.
REQ-028 SHALL compute accumulates modulo 2^32 (32-bit ops) or 2^64 (64-bit ops), dropping the final carry.
REQ-029 SHALL ignore start while busy=1; no queuing and no corruption of latched fields.
REQ-030 SHALL, when rd_lo==rd_hi, perform both writes in order, so the high word remains.
REQ-031 SHALL drive rf_we=0, rf_waddr=0 and rf_wdata=0 outside the WR states.
REQ-032 SHALL accept start in the cycle immediately after done (IDLE reached), giving back-to-back operation.

Reset
REQ-033 SHALL, while RST_N=0, force IDLE and clear all outputs (LD_MUL, Gate_MUL, MUL_HiLo, U, busy, rf_we, done) and all latched fields to 0.
REQ-034 SHALL abort any operation when RST_N asserts mid-operation, with no write issued afterwards.
REQ-035 SHALL resume normal operation on the first rising CLK edge after RST_N deasserts.

Configuration
REQ-036 SHALL, with MUL_WB_ACC_EN defined, implement accumulate per REQ-026 to REQ-028.
REQ-037 SHALL, without MUL_WB_ACC_EN, treat acc as 0, leave acc_lo and acc_hi unused, and omit the adder; the state sequence is unchanged.

Verification
REQ-038 SHALL pass: UMULL A=0xFFFFFFFF, B=0xFFFFFFFF, rd_lo=2, rd_hi=3 -> T+4 writes r2=0x00000001, T+5 writes r3=0xFFFFFFFE, done at T+5.
REQ-039 SHALL pass: SMULL A=0xFFFFFFFF (-1), B=2 -> lo=0xFFFFFFFE, hi=0xFFFFFFFF, and U=1 throughout.
REQ-040 SHALL pass: MLA A=3, B=4, acc_lo=5, rd_lo=7 -> single write r7=0x00000011 at T+3, done at T+3, no WR_HI.
REQ-041 SHALL pass: UMLAL A=1, B=1, acc_lo=0xFFFFFFFF, acc_hi=0 -> lo=0x00000000, hi=0x00000001 (carry propagated).
REQ-042 SHALL pass: start pulsed again at T+2 of a long op -> ignored, exactly two writes, busy drops after T+5.
REQ-043 SHALL pass: RST_N low at T+3 of a long op -> immediate IDLE, all outputs 0, no rf_we afterwards.
